sevenseg_scan: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 17 +
 rtl/sevenseg_scan_timer.sv | 51 +++++
 rtl/sevenseg_scan.sv | 114 +++++++++++
 tb/tb_sevenseg_scan.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared scan state type, default timing constants and anode fill helper
package sevenseg_pkg;

   typedef enum logic [1:0] {IDLE, GUARD, DRIVE} scan_state_t;

   localparam int DEF_NUM_DIGITS   = 8;
   localparam int DEF_REFRESH_DIV  = 100000;
   localparam int DEF_GUARD_CYCLES = 16;
   localparam int MAX_DIGITS       = 32;

   // all anodes released (active-low) for an n-digit display
   function automatic logic [MAX_DIGITS-1:0] anode_off(input int n);
      anode_off = '0;
      for (int i = 0; i < MAX_DIGITS; i++) anode_off[i] = (i < n);
   endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// scan_timer: slot counter and digit index with wrap detect; SEVENSEG_SCAN_GUARD_EN adds slot/guard terminal counts
module scan_timer
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
`ifdef SEVENSEG_SCAN_GUARD_EN
   ,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          run,
   output logic [$clog2(NUM_DIGITS)-1:0] idx,
`ifdef SEVENSEG_SCAN_GUARD_EN
   output logic                          slot_end,
   output logic                          guard_end,
`endif
   output logic                          wrap
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0] cnt;
   logic          tc;
   logic          last;

   assign last = idx == IW'(NUM_DIGITS - 1);
   assign tc   = run && cnt == CW'(REFRESH_DIV - 1);
   assign wrap = tc && last;
`ifdef SEVENSEG_SCAN_GUARD_EN
   assign slot_end  = tc;
   assign guard_end = cnt == CW'(GUARD_CYCLES - 1);
`endif

   // count cycles within a slot and step the digit index; both park at zero while not running
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!run) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tc ? '0 : cnt + CW'(1);
         idx <= !tc ? idx : last ? '0 : idx + IW'(1);
      end

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed hex digit scanner with frame-synchronous double buffering; SEVENSEG_SCAN_GUARD_EN adds anode-off guard cycles
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [3:0]              num,
   output logic                    dp,
   output logic                    frame_tick,
   output logic                    busy
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(anode_off(NUM_DIGITS));

   if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS || REFRESH_DIV < 2 || GUARD_CYCLES >= REFRESH_DIV) begin : g_bad_params
      $error("sevenseg_scan: invalid parameter set");
   end

   scan_state_t             state;
   logic [IW-1:0]           idx;
   logic                    wrap;
   logic                    run;
   logic [4*NUM_DIGITS-1:0] act_val, sh_val;
   logic [NUM_DIGITS-1:0]   act_dp, sh_dp;
   logic                    pending;

   assign run  = enable && state != IDLE;
   assign busy = pending;

`ifdef SEVENSEG_SCAN_GUARD_EN
   logic slot_end, guard_end;

   scan_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD_CYCLES(GUARD_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .idx      (idx),
      .slot_end (slot_end),
      .guard_end(guard_end),
      .wrap     (wrap)
   );

   // every slot opens with guard cycles before its anode is driven
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= !enable ? IDLE :
                    state == IDLE  ? GUARD :
                    state == GUARD ? (guard_end ? DRIVE : GUARD) :
                    (slot_end ? GUARD : DRIVE);
`else
   scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .REFRESH_DIV(REFRESH_DIV)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .idx  (idx),
      .wrap (wrap)
   );

   // without guard cycles the anode is driven for the whole slot
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= enable ? DRIVE : IDLE;
`endif

   // shadow takes loads; active only changes on a frame wrap so a frame is never torn
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         act_val <= '0;
         act_dp  <= '0;
         sh_val  <= '0;
         sh_dp   <= '0;
         pending <= 1'b0;
      end else if (wrap) begin
         act_val <= load ? value : pending ? sh_val : act_val;
         act_dp  <= load ? dp_in : pending ? sh_dp : act_dp;
         pending <= 1'b0;
      end else if (load) begin
         sh_val  <= value;
         sh_dp   <= dp_in;
         pending <= 1'b1;
      end

   // registered display outputs; a dropped enable blanks the anodes on the very next cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         an         <= AN_OFF;
         num        <= '0;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= (enable && state == DRIVE) ? ~(NUM_DIGITS'(1) << idx) : AN_OFF;
         num        <= act_val[{idx, 2'b00} +: 4];
         dp         <= ~act_dp[idx];
         frame_tick <= wrap;
      end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench; stimulus queues expected digit slots, a monitor checks each completed slot
module tb_sevenseg_scan;

`ifdef SEVENSEG_SCAN_GUARD_EN
   localparam int L = 6, O = 2, P = 3;
`else
   localparam int L = 8, O = 0, P = 5;
`endif

   logic        clk = 1'b0;
   logic        rst_n, enable, load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  an, num;
   logic        dp, frame_tick, busy;

   int checks = 0, errors = 0;

   typedef struct {
      logic [3:0] an;
      logic [3:0] num;
      logic       dp;
      int         len;
      int         off;
   } slot_t;

   slot_t q[$];
   bit    strict = 1'b1;

   sevenseg_scan #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .GUARD_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .load      (load),
      .value     (value),
      .dp_in     (dp_in),
      .an        (an),
      .num       (num),
      .dp        (dp),
      .frame_tick(frame_tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_slot(input int d, input logic [15:0] v, input logic [3:0] dpm, input int len, input int off);
      slot_t s;
      s.an  = ~(4'b0001 << d);
      s.num = v[d*4 +: 4];
      s.dp  = ~dpm[d];
      s.len = len;
      s.off = off;
      q.push_back(s);
   endtask

   task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm, input bit first);
      for (int d = 0; d < 4; d++) push_slot(d, v, dpm, L, (first && d == 0) ? -1 : O);
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      chk("frame_tick_seen", frame_tick, 1'b1);
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      load  = 1'b1;
      value = v;
      dp_in = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   // monitor: measure each anode-low run and compare against the queued expectation
   logic [3:0] prev_an = 4'hF, s_num;
   logic       s_dp;
   int         run_len, off_len, slot_off, cyc = 0, last_tick = -1;
   bit         torn;

   task automatic emit(input logic [3:0] a, input logic [3:0] n, input logic d, input int len, input int off, input bit t);
      slot_t e;
      if (q.size() == 0) begin
         if (strict) chk("unexpected_slot_an", a, 4'hF);
      end else begin
         e = q.pop_front();
         chk("slot_an", a, e.an);
         chk("slot_num", n, e.num);
         chk("slot_dp", d, e.dp);
         chk("slot_len", len, e.len);
         if (e.off >= 0) chk("slot_guard_len", off, e.off);
         chk("slot_stable", t, 1'b0);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_an   = 4'hF;
         off_len   = 0;
         last_tick = -1;
      end else begin
         chk("one_anode_max", $countones(~an) <= 1, 1'b1);
         if (frame_tick) begin
            if (last_tick >= 0) chk("frame_period", cyc - last_tick, 32);
            last_tick = cyc;
         end
         if (!enable) last_tick = -1;
         if (an != prev_an) begin
            if (prev_an != 4'hF) emit(prev_an, s_num, s_dp, run_len, slot_off, torn);
            if (an != 4'hF) begin
               s_num    = num;
               s_dp     = dp;
               run_len  = 1;
               slot_off = off_len;
               torn     = 1'b0;
            end
            off_len = (an == 4'hF) ? 1 : 0;
         end else if (an == 4'hF) begin
            off_len++;
         end else begin
            run_len++;
            if (num !== s_num || dp !== s_dp) torn = 1'b1;
         end
         prev_an = an;
      end
   end

   initial begin
      rst_n  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      value  = '0;
      dp_in  = '0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_num", num, 4'h0);
      chk("rst_dp", dp, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tick", frame_tick, 1'b0);
      rst_n  = 1'b1;
      enable = 1'b1;
      push_frame(16'h0000, 4'h0, 1'b1);
      wait_tick();
      push_frame(16'h0000, 4'h0, 1'b0);
      repeat (10) @(negedge clk);
      pulse_load(16'hA5C3, 4'h0);
      chk("busy_pending", busy, 1'b1);
      wait_tick();
      chk("busy_commit", busy, 1'b0);
      push_frame(16'hA5C3, 4'h0, 1'b0);
      repeat (31) @(negedge clk);
      pulse_load(16'h1234, 4'h0);
      chk("fwd_on_tick", frame_tick, 1'b1);
      chk("fwd_busy", busy, 1'b0);
      push_frame(16'h1234, 4'h0, 1'b0);
      repeat (5) @(negedge clk);
      pulse_load(16'h1111, 4'b0001);
      repeat (5) @(negedge clk);
      pulse_load(16'h2222, 4'b0010);
      chk("double_busy", busy, 1'b1);
      wait_tick();
      chk("double_commit", busy, 1'b0);
      push_slot(0, 16'h2222, 4'b0010, L, O);
      push_slot(1, 16'h2222, 4'b0010, L, O);
      push_slot(2, 16'h2222, 4'b0010, P, O);
      repeat (21) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("drop_an", an, 4'hF);
      pulse_load(16'h5555, 4'b0100);
      repeat (20) @(negedge clk);
      chk("idle_busy_held", busy, 1'b1);
      chk("idle_an", an, 4'hF);
      chk("idle_tick", frame_tick, 1'b0);
      enable = 1'b1;
      push_frame(16'h2222, 4'b0010, 1'b1);
      wait_tick();
      chk("reenable_commit", busy, 1'b0);
      push_frame(16'h5555, 4'b0100, 1'b0);
      wait_tick();
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      strict = 1'b0;
      enable = 1'b0;
      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
